// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: pulls words via rdreq and serialises them
// with configurable data width, parity and stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQURENCE = 12000000,
  parameter int BAUD_RATE      = 115200,
  parameter int BIT_CNT        = CLK_FREQURENCE / BAUD_RATE,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 sysclk_12,
  input  logic                 i_rest_n,
  input  logic                 uart_en,
  input  logic                 rdempty,
  input  logic [DATA_BITS-1:0] paralle_data,
  output logic                 rdreq,
  output logic                 tx_data,
  output logic                 send_sta_flg,
  output logic                 byte_done
);

  localparam int CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CNT - 1);
  localparam logic [2:0] LAST_D = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_S = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, RDREQ, LOAD, START, DATA, PAR, STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 rdreq_q, rdreq_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_ff @(posedge sysclk_12 or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rdreq_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (uart_en && !rdempty) begin
          state_d = RDREQ;
          rdreq_d = 1'b1;
        end
      end
      RDREQ: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        shreg_d = paralle_data;
        par_d   = (PARITY == 1) ? ~^paralle_data
                                : ^paralle_data;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        state_d = START;
      end
      START: begin
        if (wrap) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (wrap) begin
          if (idx_q == LAST_D) begin
            idx_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PAR: begin
        if (wrap) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // idx counts stop bits here so the full stop time is always sent
        if (wrap) begin
          if (idx_q == LAST_S) begin
            idx_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_12 or negedge i_rest_n) begin
    if (!i_rest_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdreq_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdreq_q <= rdreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rdreq        = rdreq_q;
  assign tx_data      = tx_q;
  assign send_sta_flg = busy_q;
  assign byte_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 main instance plus two
// 7-bit, 2-stop instances with even and odd parity.
module tb_uart_tx_fifo;

  localparam int BC = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic       en_m = 1'b0;
  logic [7:0] mem [0:15];
  logic [3:0] rd_ptr = 4'd0;
  logic [3:0] wr_ptr = 4'd0;
  logic [7:0] pdata_m = 8'd0;
  logic       rdempty_m;
  logic       rdreq_m, tx_m, busy_m, done_m;

  logic       en_p = 1'b0;
  logic       emp_p = 1'b1;
  logic [6:0] data_p = 7'h41;
  logic       rdreq_e, tx_e, busy_e, done_e;
  logic       rdreq_o, tx_o, busy_o, done_o;

  assign rdempty_m = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rdreq_m) begin
      pdata_m <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 4'd1;
    end
  end

  uart_tx_fifo u_dut (
    .sysclk_12    (clk),
    .i_rest_n     (rst_n),
    .uart_en      (en_m),
    .rdempty      (rdempty_m),
    .paralle_data (pdata_m),
    .rdreq        (rdreq_m),
    .tx_data      (tx_m),
    .send_sta_flg (busy_m),
    .byte_done    (done_m)
  );

  uart_tx_fifo #(
    .DATA_BITS (7), .PARITY (2), .STOP_BITS (2)
  ) u_even (
    .sysclk_12    (clk),
    .i_rest_n     (rst_n),
    .uart_en      (en_p),
    .rdempty      (emp_p),
    .paralle_data (data_p),
    .rdreq        (rdreq_e),
    .tx_data      (tx_e),
    .send_sta_flg (busy_e),
    .byte_done    (done_e)
  );

  uart_tx_fifo #(
    .DATA_BITS (7), .PARITY (1), .STOP_BITS (2)
  ) u_odd (
    .sysclk_12    (clk),
    .i_rest_n     (rst_n),
    .uart_en      (en_p),
    .rdempty      (emp_p),
    .paralle_data (data_p),
    .rdreq        (rdreq_o),
    .tx_data      (tx_o),
    .send_sta_flg (busy_o),
    .byte_done    (done_o)
  );

  int  tests = 0;
  int  fails = 0;
  int  rdreq_cnt = 0;
  int  viol = 0;
  time rdreq_t = 0;
  time fall_t = 0;

  always @(negedge clk) begin
    if (rdreq_m) begin
      rdreq_cnt++;
      rdreq_t = $time;
    end
    if (rdreq_m && rdempty_m) viol++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic txs(input int s);
    case (s)
      0:       return tx_m;
      1:       return tx_e;
      default: return tx_o;
    endcase
  endfunction

  function automatic logic dns(input int s);
    case (s)
      0:       return done_m;
      1:       return done_e;
      default: return done_o;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      0:       return busy_m;
      1:       return busy_e;
      default: return busy_o;
    endcase
  endfunction

  task automatic wait_fall(input int s, input string tag,
                           output int hi);
    logic seen;
    seen = 1'b0;
    hi = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (txs(s) == 1'b0) seen = 1'b1;
      else hi++;
    end
    fall_t = $time;
    chk({tag, " start"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic frame(input int s, input string tag,
                       input logic [7:0] d, input int nd,
                       input int par, input int ns);
    logic b [12];
    int   n, ones, cnt;
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      b[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = 1 + nd;
    if (par != 0) begin
      b[n] = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      b[n] = 1'b1;
      n++;
    end
    chk({tag, " busy"}, {31'd0, bsy(s)}, 32'd1);
    for (int k = 0; k < n; k++) begin
      cnt = (k == 0) ? 1 : 0;
      repeat ((k == 0) ? BC - 1 : BC) begin
        @(negedge clk);
        if (txs(s) === b[k] && dns(s) == 1'b0) cnt++;
      end
      chk($sformatf("%s bit%0d", tag, k), cnt, BC);
    end
    @(negedge clk);
    chk({tag, " done"}, {31'd0, dns(s)}, 32'd1);
    chk({tag, " idle"}, {31'd0, bsy(s)}, 32'd0);
  endtask

  initial begin
    int   h, h1, h2, low, base;
    logic seen;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst tx", {31'd0, tx_m}, 32'd1);
    chk("rst rdreq", {31'd0, rdreq_m}, 32'd0);
    chk("rst busy", {31'd0, busy_m}, 32'd0);
    chk("rst done", {31'd0, done_m}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[0] = 8'hA5;
    wr_ptr = 4'd1;
    en_m = 1'b1;
    wait_fall(0, "a5", h);
    chk("a5 req2tx", 32'(int'((fall_t - rdreq_t) / 10)), 32'd2);
    frame(0, "a5", 8'hA5, 8, 0, 1);
    chk("a5 reqs", rdreq_cnt, 1);

    en_p = 1'b1;
    emp_p = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rdreq_e && rdreq_o) seen = 1'b1;
    end
    emp_p = 1'b1;
    chk("par rdreq", {31'd0, seen}, 32'd1);
    fork
      begin
        wait_fall(1, "even", h1);
        frame(1, "even", 8'h41, 7, 2, 2);
      end
      begin
        wait_fall(2, "odd", h2);
        frame(2, "odd", 8'h41, 7, 1, 2);
      end
    join

    mem[1] = 8'h01;
    mem[2] = 8'h02;
    mem[3] = 8'h03;
    wr_ptr = 4'd4;
    wait_fall(0, "w1", h);
    frame(0, "w1", 8'h01, 8, 0, 1);
    wait_fall(0, "w2", h);
    chk("gap12", h + 1, 3);
    frame(0, "w2", 8'h02, 8, 0, 1);
    wait_fall(0, "w3", h);
    chk("gap23", h + 1, 3);
    frame(0, "w3", 8'h03, 8, 0, 1);
    low = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx_m) low++;
    end
    chk("drain tx", low, 0);
    chk("drain reqs", rdreq_cnt, 4);

    mem[4] = 8'h3C;
    mem[5] = 8'hC3;
    wr_ptr = 4'd6;
    wait_fall(0, "en0", h);
    fork
      frame(0, "en0", 8'h3C, 8, 0, 1);
      begin
        repeat (BC + BC / 2) @(negedge clk);
        en_m = 1'b0;
      end
    join
    repeat (500) @(negedge clk);
    chk("en off reqs", rdreq_cnt, 5);
    en_m = 1'b1;
    wait_fall(0, "en1", h);
    chk("en on reqs", rdreq_cnt, 6);
    frame(0, "en1", 8'hC3, 8, 0, 1);

    mem[6] = 8'h55;
    mem[7] = 8'h0F;
    wr_ptr = 4'd8;
    wait_fall(0, "r0", h);
    repeat (4 * BC) @(negedge clk);
    chk("pre rst tx", {31'd0, tx_m}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async tx", {31'd0, tx_m}, 32'd1);
    chk("async busy", {31'd0, busy_m}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_fall(0, "r1", h);
    frame(0, "r1", 8'h0F, 8, 0, 1);
    chk("rst reqs", rdreq_cnt, 8);

    base = rdreq_cnt;
    low = 0;
    repeat (10000) begin
      @(negedge clk);
      if (!tx_m) low++;
    end
    chk("empty reqs", rdreq_cnt, base);
    chk("empty tx", low, 0);
    chk("req while empty", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
